// File: rtl/adjust_if.sv
// Button-adjust bus: debounced button level and channel select in,
// per-channel adjust pulses, LED mirror and busy flag out.
interface adjust_if #(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = 2
);
    logic              ADJ;
    logic [SEL_W-1:0]  adj_sel;
    logic [NUM_CH-1:0] sig_adj;
    logic [NUM_CH-1:0] led;
    logic              busy;

    modport master (
        output ADJ, adj_sel,
        input  sig_adj, led, busy
    );

    modport slave (
        input  ADJ, adj_sel,
        output sig_adj, led, busy
    );
endinterface

// File: rtl/adjust_ctrl.sv
// Press/hold button controller: a short press yields one fixed-width pulse on
// the selected channel, a long hold either auto-repeats or is discarded.
module adjust_ctrl #(
    parameter int NUM_CH        = 2,
    parameter int SEL_W         = 2,
    parameter int CNT_W         = 4,
    parameter int MIN_HOLD      = 4,
    parameter int REPEAT_START  = 13,
    parameter int PULSE_LEN     = 3,
    parameter int REPEAT_PERIOD = 8,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic     clk_adj,
    input  logic     reset,
    adjust_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        PULSE,
        REPEAT,
        DISCARD
    } state_t;

    localparam logic [SEL_W-1:0] NUM_CH_SEL  = SEL_W'(NUM_CH);
    localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(REPEAT_START - 1);
    localparam logic [CNT_W-1:0] MIN_HOLD_C  = CNT_W'(MIN_HOLD);
    localparam logic [CNT_W-1:0] PULSE_LEN_C = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  hold_cnt_reg, hold_cnt_next;
    logic [CNT_W-1:0]  per_cnt_reg, per_cnt_next;
    logic [SEL_W-1:0]  ch_reg, ch_next;
    logic [NUM_CH-1:0] sig_adj_reg;
    logic              sig_on_next;
    logic              sel_valid;

    assign sel_valid = (bus.adj_sel != '0) && (bus.adj_sel <= NUM_CH_SEL);

    always_ff @(posedge clk_adj) begin
        if (reset) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            per_cnt_reg  <= '0;
            ch_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            per_cnt_reg  <= per_cnt_next;
            ch_reg       <= ch_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        per_cnt_next  = per_cnt_reg;
        ch_next       = ch_reg;
        sig_on_next   = 1'b0;
        if (!sel_valid) begin
            // Deselecting the channel aborts whatever is in flight.
            state_next    = IDLE;
            hold_cnt_next = '0;
            per_cnt_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.ADJ) begin
                        state_next    = HOLD;
                        hold_cnt_next = CNT_ONE;
                        per_cnt_next  = '0;
                        ch_next       = bus.adj_sel - SEL_ONE;
                    end
                end
                HOLD: begin
                    if (bus.ADJ) begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            if (REPEAT_EN) begin
                                state_next   = REPEAT;
                                per_cnt_next = '0;
                                sig_on_next  = 1'b1;
                            end else begin
                                state_next = DISCARD;
                            end
                        end else begin
                            hold_cnt_next = hold_cnt_reg + CNT_ONE;
                        end
                    end else if (hold_cnt_reg >= MIN_HOLD_C) begin
                        state_next   = PULSE;
                        per_cnt_next = CNT_ONE;
                        sig_on_next  = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end
                end
                PULSE: begin
                    // per_cnt counts pulse cycles already issued, starting at 1.
                    if (per_cnt_reg == PULSE_LEN_C) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                        per_cnt_next  = '0;
                    end else begin
                        per_cnt_next = per_cnt_reg + CNT_ONE;
                        sig_on_next  = 1'b1;
                    end
                end
                REPEAT: begin
                    if (bus.ADJ) begin
                        per_cnt_next = (per_cnt_reg == PERIOD_LAST) ? '0 : per_cnt_reg + CNT_ONE;
                        sig_on_next  = (per_cnt_next < PULSE_LEN_C);
                    end else begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                        per_cnt_next  = '0;
                    end
                end
                DISCARD: begin
                    if (!bus.ADJ) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                    per_cnt_next  = '0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sig
            always_ff @(posedge clk_adj) begin
                if (reset) begin
                    sig_adj_reg[gi] <= 1'b0;
                end else begin
                    sig_adj_reg[gi] <= sig_on_next && (ch_next == SEL_W'(gi));
                end
            end
        end
    endgenerate

    assign bus.sig_adj = sig_adj_reg;
    assign bus.led     = sig_adj_reg;
    assign bus.busy    = (state_reg != IDLE);
endmodule

// File: tb/tb_adjust_ctrl.sv
// Two controllers (auto-repeat on / off) driven by the same stimulus and
// compared every cycle against a press-length model, plus literal spot checks.
module tb_adjust_ctrl;
    localparam int NCH = 2;
    localparam int RS  = 13;
    localparam int MH  = 4;
    localparam int PL  = 3;
    localparam int RP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adj = 1'b0;
    logic [1:0] sel = 2'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adjust_if #(.NUM_CH(NCH), .SEL_W(2)) if0 ();
    adjust_if #(.NUM_CH(NCH), .SEL_W(2)) if1 ();

    assign if0.ADJ     = adj;
    assign if0.adj_sel = sel;
    assign if1.ADJ     = adj;
    assign if1.adj_sel = sel;

    adjust_ctrl #(.REPEAT_EN(1'b1)) dut0 (.clk_adj(clk), .reset(rst), .bus(if0));
    adjust_ctrl #(.REPEAT_EN(1'b0)) dut1 (.clk_adj(clk), .reset(rst), .bus(if1));

    // Model: mode 0 idle, 1 pressing, 2 short-press pulse, 3 long hold.
    int m_mode [2];
    int m_held [2];
    int m_rel  [2];
    int m_ch   [2];

    function automatic logic [1:0] exp_sig(input int i);
        logic [1:0] onehot;
        onehot = (m_ch[i] == 1) ? 2'b10 : 2'b01;
        if (m_mode[i] == 2) return onehot;
        if (m_mode[i] == 3 && i == 0 && ((m_held[i] - RS) % RP) < PL) return onehot;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic cyc(input logic a, input logic [1:0] s, input logic r);
        adj = a;
        sel = s;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_held[i] = 0; m_rel[i] = 0; m_ch[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst || sel == 2'd0 || sel > 2'd2) begin
                    m_mode[i] = 0;
                end else begin
                    case (m_mode[i])
                        0: if (adj) begin
                            m_mode[i] = 1; m_held[i] = 1; m_ch[i] = int'(sel) - 1;
                        end
                        1: if (adj) begin
                            m_held[i]++;
                            if (m_held[i] == RS) m_mode[i] = 3;
                        end else if (m_held[i] >= MH) begin
                            m_mode[i] = 2; m_rel[i] = 0;
                        end else begin
                            m_mode[i] = 0;
                        end
                        2: begin
                            m_rel[i]++;
                            if (m_rel[i] == PL) m_mode[i] = 0;
                        end
                        default: if (adj) m_held[i]++; else m_mode[i] = 0;
                    endcase
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model sig0", 32'(if0.sig_adj), 32'(exp_sig(0)));
            chk("model led0", 32'(if0.led), 32'(exp_sig(0)));
            chk("model busy0", 32'(if0.busy), 32'(m_mode[0] != 0));
            chk("model sig1", 32'(if1.sig_adj), 32'(exp_sig(1)));
            chk("model led1", 32'(if1.led), 32'(exp_sig(1)));
            chk("model busy1", 32'(if1.busy), 32'(m_mode[1] != 0));
        end
    end

    initial begin
        logic       r_adj;
        logic [1:0] r_sel;
        int         run;

        cyc(1'b0, 2'd0, 1'b1);
        cyc(1'b0, 2'd0, 1'b1);
        chk("reset sig", 32'(if0.sig_adj), 32'h0);
        chk("reset busy", 32'(if0.busy), 32'h0);

        // Short press of 6 edges on channel 0.
        for (int k = 0; k < 6; k++) cyc(1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'd1, 1'b0);
            chk("press6 pulse", 32'(if0.sig_adj), 32'h1);
        end
        cyc(1'b0, 2'd1, 1'b0);
        chk("press6 end sig", 32'(if0.sig_adj), 32'h0);
        chk("press6 end busy", 32'(if0.busy), 32'h0);

        // Too-short press.
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b0, 2'd1, 1'b0);
        chk("press3 sig", 32'(if0.sig_adj), 32'h0);
        chk("press3 busy", 32'(if0.busy), 32'h0);

        // Long hold on channel 1, released mid-pulse.
        for (int k = 1; k <= 22; k++) begin
            cyc(1'b1, 2'd2, 1'b0);
            if (k == 12) chk("hold12 sig", 32'(if0.sig_adj), 32'h0);
            if (k == 13) chk("hold13 sig", 32'(if0.sig_adj), 32'h2);
            if (k == 15) chk("hold15 sig", 32'(if0.sig_adj), 32'h2);
            if (k == 16) chk("hold16 sig", 32'(if0.sig_adj), 32'h0);
            if (k == 21) chk("hold21 sig", 32'(if0.sig_adj), 32'h2);
            if (k == 22) begin
                chk("discard busy", 32'(if1.busy), 32'h1);
                chk("discard sig", 32'(if1.sig_adj), 32'h0);
            end
        end
        cyc(1'b0, 2'd2, 1'b0);
        chk("release sig", 32'(if0.sig_adj), 32'h0);
        chk("release busy", 32'(if0.busy), 32'h0);
        chk("discard end busy", 32'(if1.busy), 32'h0);

        // Disabled select, then abort during pulse.
        for (int k = 0; k < 3; k++) cyc(1'b1, 2'd0, 1'b0);
        chk("sel0 busy", 32'(if0.busy), 32'h0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b0, 2'd1, 1'b0);
        chk("abort pre sig", 32'(if0.sig_adj), 32'h1);
        cyc(1'b0, 2'd0, 1'b0);
        chk("abort sig", 32'(if0.sig_adj), 32'h0);
        chk("abort busy", 32'(if0.busy), 32'h0);

        // Reset during repeat, then a fresh press count.
        for (int k = 0; k < 14; k++) cyc(1'b1, 2'd1, 1'b0);
        cyc(1'b1, 2'd1, 1'b1);
        chk("rst rep sig", 32'(if0.sig_adj), 32'h0);
        chk("rst rep busy", 32'(if0.busy), 32'h0);
        for (int k = 0; k < 12; k++) cyc(1'b1, 2'd1, 1'b0);
        chk("post rst 12 sig", 32'(if0.sig_adj), 32'h0);
        chk("post rst 12 busy", 32'(if0.busy), 32'h1);
        cyc(1'b1, 2'd1, 1'b0);
        chk("post rst 13 sig", 32'(if0.sig_adj), 32'h1);
        cyc(1'b0, 2'd1, 1'b0);

        // Random presses of varied length with occasional select changes/resets.
        r_adj = 1'b0;
        r_sel = 2'd1;
        run   = 0;
        for (int n = 0; n < 4000; n++) begin
            if (run == 0) begin
                r_adj = ~r_adj;
                run   = r_adj ? int'($urandom_range(1, 26)) : int'($urandom_range(1, 6));
            end
            run--;
            if ($urandom_range(0, 59) == 0) r_sel = 2'($urandom_range(0, 3));
            cyc(r_adj, r_sel, ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adjust_ctrl.md
ADJUST_CTRL -- requirements
Module: adjust_ctrl

Interface
REQ-001 SHALL expose parameters (name, default, meaning) exactly as listed in REQ-002..REQ-008.
REQ-002 NUM_CH, 2, number of adjustable channels.
REQ-003 SEL_W, 2, width of adj_sel; 2^SEL_W SHALL exceed NUM_CH.
REQ-004 CNT_W, 4, width of hold and period counters.
REQ-005 MIN_HOLD, 4, minimum sampled-high edges for a valid press.
REQ-006 REPEAT_START, 13, held edges that trigger repeat or discard; MIN_HOLD < REPEAT_START <= 2^CNT_W-1.
REQ-007 PULSE_LEN / REPEAT_PERIOD, 3 / 8, pulse width and repeat period in cycles; 1 <= PULSE_LEN < REPEAT_PERIOD <= 2^CNT_W-1.
REQ-008 REPEAT_EN, 1, 1 = auto-repeat on long hold, 0 = long hold discarded.
REQ-009 Ports (name direction width meaning): clk_adj in 1 adjust clock; all logic on rising edge.
REQ-010 reset in 1 synchronous active-high reset.
REQ-011 ADJ in 1 adjust button level, already debounced.
REQ-012 adj_sel in SEL_W; 0 = adjust disabled, k in 1..NUM_CH selects channel k-1, values > NUM_CH treated as 0.
REQ-013 sig_adj out NUM_CH registered adjust pulses, at most one bit high.
REQ-014 led out NUM_CH, equal to sig_adj.
REQ-015 busy out 1, high whenever state != IDLE.

Function
REQ-016 States SHALL be IDLE, HOLD, PULSE, REPEAT, DISCARD.
REQ-017 IDLE: ADJ=1 and valid adj_sel -> HOLD, hold_cnt=1, ch_q latched = adj_sel-1; otherwise stay.
REQ-018 HOLD, ADJ=1: hold_cnt increments; on the edge where hold_cnt==REPEAT_START-1, go REPEAT (REPEAT_EN=1) or DISCARD (REPEAT_EN=0).
REQ-019 HOLD, ADJ=0: hold_cnt >= MIN_HOLD -> PULSE; else -> IDLE, no output.
REQ-020 PULSE: sig_adj[ch_q] SHALL be high for exactly PULSE_LEN cycles, the first cycle following the transition edge, then IDLE; ADJ ignored while in PULSE.
REQ-021 REPEAT: sig_adj[ch_q] high from the entry edge for PULSE_LEN cycles, low for REPEAT_PERIOD-PULSE_LEN cycles, repeating while ADJ=1.
REQ-022 REPEAT, ADJ sampled 0: sig_adj cleared at that edge (pulse truncated), go IDLE.
REQ-023 DISCARD: no output; ADJ sampled 0 -> IDLE.
REQ-024 adj_sel becoming 0/invalid in any state SHALL abort: sig_adj=0 and state=IDLE at that edge.
REQ-025 adj_sel changing to another valid channel mid-operation SHALL be ignored; ch_q holds.
REQ-026 Counters SHALL never wrap; hold_cnt cannot exceed REPEAT_START-1.
REQ-027 Press started in IDLE on the edge PULSE exits is not possible; the first IDLE edge samples ADJ anew.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, hold_cnt=0, period counter=0, ch_q=0, sig_adj=0, busy=0, overriding all other inputs, including mid-PULSE/REPEAT.
REQ-029 After reset release, ADJ already high SHALL be treated as a new press starting at hold_cnt=1.

Verification (defaults)
REQ-030 adj_sel=1, ADJ high 6 edges then low -> sig_adj=01 for 3 cycles after release edge, busy=0 afterwards.
REQ-031 adj_sel=1, ADJ high 3 edges then low -> sig_adj stays 00, IDLE after release edge.
REQ-032 adj_sel=2, ADJ held 30 edges -> sig_adj=10 from 13th edge, 3 high / 5 low repeating; release mid-pulse -> 00 at release edge.
REQ-033 REPEAT_EN=0, ADJ held 20 edges -> no pulse, busy until release, then IDLE.
REQ-034 adj_sel=0 with ADJ high -> no activity; adj_sel 1->0 during PULSE -> sig_adj=00 at that edge.
REQ-035 reset asserted during REPEAT with ADJ high -> all outputs 0 next edge; after release, repeat restarts only after 12 more held edges.
